seq_rem_unit: RTL and testbench

//  Multi-cycle sign-magnitude remainder engine with a start/done handshake.

---
 rtl/rem_pkg.sv | 17 +
 rtl/rem_step.sv | 23 ++
 rtl/seq_rem_unit.sv | 108 ++++++++++
 tb/tb_seq_rem_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rem_pkg.sv
// Shared types and constants for the sequential sign-magnitude remainder unit.
package rem_pkg;

  localparam int unsigned REM_W = 3;
  localparam int unsigned MAG   = REM_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic [MAG-1:0] sm_mag(input logic [REM_W-1:0] x);
    return x[MAG-1:0];
  endfunction

endpackage

// File: rtl/rem_step.sv
// One restoring shift-subtract step: shift the next dividend bit in, subtract the divisor if it fits.
module rem_step #(
  parameter int unsigned M = 2
) (
  input  logic [M-1:0] rem,
  input  logic [M-1:0] divisor,
  input  logic         nextBit,
  output logic [M-1:0] remNext
);

  logic [M:0] shifted;

  // The incoming rem is always below divisor, so the result fits back in M bits.
  always_comb begin
    shifted = {rem, nextBit};
    if (shifted >= {1'b0, divisor}) begin
      remNext = M'(shifted - {1'b0, divisor});
    end else begin
      remNext = shifted[M-1:0];
    end
  end

endmodule

// File: rtl/seq_rem_unit.sv
// Multi-cycle sign-magnitude remainder engine (NumA mod NumB), one quotient bit per clock.
module seq_rem_unit
  import rem_pkg::*;
#(
  parameter int unsigned W = REM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] NumA,
  input  logic [W-1:0] NumB,
  output logic         busy,
  output logic         done,
  output logic [W:0]   Res,
  output logic         negF,
  output logic         zerF,
  output logic         DZF
);

  localparam int unsigned M  = W - 1;
  localparam int unsigned CW = $clog2(W);

  state_t        state, stateNext;
  logic [CW-1:0] count;
  logic [M-1:0]  rem, dvd, dvs, remNext;
  logic          aSign;
  logic          accept, stepEn, latchRes;
  logic          divZero, resSign;
  logic          unusedBSign;

  // The remainder takes the dividend's sign; the divisor sign never matters.
  assign unusedBSign = NumB[W-1];

  rem_step #(.M(M)) uStep (
    .rem    (rem),
    .divisor(dvs),
    .nextBit(dvd[M-1]),
    .remNext(remNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (count == CW'(1)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    accept   = (state == IDLE) && start;
    stepEn   = (state == CALC);
    latchRes = (state == DONE);
  end

  assign divZero = (dvs == '0);
  assign resSign = aSign && (rem != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      aSign <= 1'b0;
      done  <= 1'b0;
      Res   <= '0;
      negF  <= 1'b0;
      zerF  <= 1'b0;
      DZF   <= 1'b0;
    end else begin
      done <= latchRes;
      if (accept) begin
        aSign <= NumA[W-1];
        dvd   <= NumA[M-1:0];
        dvs   <= NumB[M-1:0];
        rem   <= '0;
        count <= CW'(M);
      end
      if (stepEn) begin
        rem   <= remNext;
        dvd   <= dvd << 1;
        count <= count - 1'b1;
      end
      if (latchRes) begin
        if (divZero) begin
          Res  <= '0;
          negF <= 1'b0;
          zerF <= 1'b1;
          DZF  <= 1'b1;
        end else begin
          Res  <= {resSign, 1'b0, rem};
          negF <= resSign;
          zerF <= (rem == '0);
          DZF  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_rem_unit.sv
// Scoreboard bench for seq_rem_unit (W=3): directed vectors, reset abort, ignored start, full sweep.
module tb_seq_rem_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] NumA, NumB;
  logic       busy, done, negF, zerF, DZF;
  logic [3:0] Res;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] res;
    logic       n;
    logic       z;
    logic       d;
    int         dueCyc;
    string      nm;
  } exp_t;

  exp_t sb[$];

  seq_rem_unit #(.W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .NumA (NumA),
    .NumB (NumB),
    .busy (busy),
    .done (done),
    .Res  (Res),
    .negF (negF),
    .zerF (zerF),
    .DZF  (DZF)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_Res"},  32'(Res),  32'(e.res));
        chk({e.nm, "_negF"}, 32'(negF), 32'(e.n));
        chk({e.nm, "_zerF"}, 32'(zerF), 32'(e.z));
        chk({e.nm, "_DZF"},  32'(DZF),  32'(e.d));
        chk({e.nm, "_busyAtDone"}, 32'(busy), 32'd0);
        chk({e.nm, "_latency"}, 32'(cyc), 32'(e.dueCyc));
      end
    end
  end

  task automatic waitIdle();
    int unsigned n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic doOp(input logic [2:0] a, input logic [2:0] b, input logic [3:0] eRes,
                      input logic eN, input logic eZ, input logic eD, input string nm);
    @(negedge clk);
    waitIdle();
    NumA  = a;
    NumB  = b;
    start = 1'b1;
    sb.push_back('{eRes, eN, eZ, eD, cyc + 1 + 3, nm});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busyAfterStart"}, 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [6:0] model(input logic [2:0] a, input logic [2:0] b);
    logic [1:0] r;
    logic       s;
    if (b[1:0] == 2'd0) return {4'b0000, 1'b0, 1'b1, 1'b1};
    r = a[1:0] % b[1:0];
    s = a[2] && (r != 2'd0);
    return {s, 1'b0, r, s, (r == 2'd0), 1'b0};
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    NumA  = '0;
    NumB  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_Res",  32'(Res),  32'd0);
    chk("rst_negF", 32'(negF), 32'd0);
    chk("rst_zerF", 32'(zerF), 32'd0);
    chk("rst_DZF",  32'(DZF),  32'd0);
    rst_n = 1'b1;

    doOp(3'b011, 3'b010, 4'b0001, 1'b0, 1'b0, 1'b0, "p3_mod_p2");
    doOp(3'b111, 3'b110, 4'b1001, 1'b1, 1'b0, 1'b0, "n3_mod_n2");
    doOp(3'b011, 3'b110, 4'b0001, 1'b0, 1'b0, 1'b0, "p3_mod_n2");
    doOp(3'b110, 3'b010, 4'b0000, 1'b0, 1'b1, 1'b0, "n2_mod_p2");
    doOp(3'b100, 3'b011, 4'b0000, 1'b0, 1'b1, 1'b0, "n0_mod_p3");
    doOp(3'b101, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, "dz_pos0");
    doOp(3'b111, 3'b100, 4'b0000, 1'b0, 1'b1, 1'b1, "dz_neg0");
    doOp(3'b010, 3'b011, 4'b0010, 1'b0, 1'b0, 1'b0, "p2_mod_p3");

    // Start pulse while busy with different operands must be ignored.
    doOp(3'b110, 3'b011, 4'b1010, 1'b1, 1'b0, 1'b0, "n2_mod_p3");
    NumA  = 3'b001;
    NumB  = 3'b001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Reset in CALC aborts: async clear, no done afterwards.
    @(negedge clk);
    NumA  = 3'b111;
    NumB  = 3'b010;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_Res",  32'(Res),  32'd0);
    chk("abort_negF", 32'(negF), 32'd0);
    chk("abort_zerF", 32'(zerF), 32'd0);
    chk("abort_DZF",  32'(DZF),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        logic [6:0] m;
        m = model(3'(a), 3'(b));
        doOp(3'(a), 3'(b), m[6:3], m[2], m[1], m[0], $sformatf("sweep_a%0d_b%0d", a, b));
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
